// File: rtl/cd_csr_arb_pkg.sv
// Shared definitions for the two-master CDBUS CSR arbiter: FSM encoding,
// bus widths, master index type and the latched command record.
package cd_csr_arb_pkg;

  localparam int CSR_AW = 4;
  localparam int CSR_DW = 32;
  localparam int CSR_BW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // One bit is enough to name either of the two masters.
  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  // Command captured from the winning master in IDLE.
  typedef struct packed {
    logic [CSR_AW-1:0] address;
    logic [CSR_BW-1:0] byteenable;
    logic [CSR_DW-1:0] writedata;
    logic              is_write;
  } cmd_t;

  // A master is requesting whenever either strobe is up.
  function automatic logic has_req(input logic read, input logic write);
    return read | write;
  endfunction

endpackage

// File: rtl/cd_csr_arb_if.sv
// One master-side CSR bus port. The master drives the request fields and
// holds them until waitrequest drops; the arbiter returns the response.
interface cd_csr_arb_if;
  import cd_csr_arb_pkg::*;

  logic [CSR_AW-1:0] address;
  logic [CSR_BW-1:0] byteenable;
  logic              read;
  logic              write;
  logic [CSR_DW-1:0] writedata;
  logic [CSR_DW-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/cd_rr_pick.sv
// Combinational two-way grant picker. A lone requester always wins; on a
// tie the winner is m0 in fixed-priority mode, otherwise the master that
// was not granted last.
module cd_rr_pick
  import cd_csr_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  mst_idx_t   last,
  output mst_idx_t   grant
);

  // Select the winner from the request pattern and the last-grant record.
  always_comb begin
    // NOTE: assign a default first so every path drives grant and no latch is inferred.
    grant = MST0;
    case (req)
      2'b01:   grant = MST0;
      2'b10:   grant = MST1;
      2'b11:   grant = FIXED_PRIO ? MST0 : mst_idx_t'(~last);
      default: grant = MST0;
    endcase
  end

endmodule

// File: rtl/cd_csr_arb.sv
// Two-master arbiter in front of the single CDBUS CSR slave. Accesses are
// serialised through IDLE -> ISSUE -> RESP so every accepted write yields
// exactly one csr_write strobe, and read data is registered per master.
module cd_csr_arb
  import cd_csr_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  cd_csr_arb_if.slave       m0,
  cd_csr_arb_if.slave       m1,
  output logic [CSR_AW-1:0] csr_address,
  output logic [CSR_BW-1:0] csr_byteenable,
  output logic              csr_read,
  output logic              csr_write,
  output logic [CSR_DW-1:0] csr_writedata,
  input  logic [CSR_DW-1:0] csr_readdata
);

  state_t                 state;
  mst_idx_t               grant_q;
  mst_idx_t               last_q;
  logic                   is_write_q;
  logic [1:0]             req;
  mst_idx_t               pick;
  cmd_t                   cmd_sel;
  logic [1:0]             waitreq_q;
  logic [1:0]             rdv_q;
  logic [1:0][CSR_DW-1:0] rdata_q;

  cd_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  // Request vector and the command fields of the master the picker chose.
  always_comb begin
    req = {has_req(m1.read, m1.write), has_req(m0.read, m0.write)};
    if (pick == MST1) begin
      cmd_sel = '{address:    m1.address,
                  byteenable: m1.byteenable,
                  writedata:  m1.writedata,
                  is_write:   m1.write};
    end else begin
      cmd_sel = '{address:    m0.address,
                  byteenable: m0.byteenable,
                  writedata:  m0.writedata,
                  is_write:   m0.write};
    end
  end

  // Transaction FSM with registered CSR strobes and master responses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state          <= ST_IDLE;
      grant_q        <= MST0;
      last_q         <= MST1;
      is_write_q     <= 1'b0;
      csr_address    <= '0;
      csr_byteenable <= '0;
      csr_read       <= 1'b0;
      csr_write      <= 1'b0;
      csr_writedata  <= '0;
      waitreq_q      <= 2'b11;
      rdv_q          <= 2'b00;
      // NOTE: the readdata registers are reset because masters may read them before any CSR read.
      rdata_q        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_q        <= pick;
            is_write_q     <= cmd_sel.is_write;
            csr_address    <= cmd_sel.address;
            csr_byteenable <= cmd_sel.byteenable;
            csr_writedata  <= cmd_sel.writedata;
            // Write wins when both strobes are up, so read is issued only without write.
            csr_write      <= cmd_sel.is_write;
            csr_read       <= ~cmd_sel.is_write;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!is_write_q) begin
            rdata_q[grant_q] <= csr_readdata;
          end
          csr_address        <= '0;
          csr_byteenable     <= '0;
          csr_read           <= 1'b0;
          csr_write          <= 1'b0;
          csr_writedata      <= '0;
          waitreq_q[grant_q] <= 1'b0;
          rdv_q[grant_q]     <= ~is_write_q;
          state              <= ST_RESP;
        end
        ST_RESP: begin
          last_q    <= grant_q;
          waitreq_q <= 2'b11;
          rdv_q     <= 2'b00;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0.readdata      = rdata_q[0];
  assign m1.readdata      = rdata_q[1];
  assign m0.readdatavalid = rdv_q[0];
  assign m1.readdatavalid = rdv_q[1];
  assign m0.waitrequest   = waitreq_q[0];
  assign m1.waitrequest   = waitreq_q[1];

endmodule

// File: tb/tb_cd_csr_arb.sv
// Bench for cd_csr_arb: one round-robin and one fixed-priority instance,
// directed scenarios with literal expectations, then randomized masters,
// all compared every cycle against a transaction-level reference model.
module tb_cd_csr_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Index [k][j]: k = instance (0 round-robin, 1 fixed priority), j = master.
  logic [1:0][1:0][3:0]  s_addr;
  logic [1:0][1:0][3:0]  s_be;
  logic [1:0][1:0]       s_rd;
  logic [1:0][1:0]       s_wr;
  logic [1:0][1:0][31:0] s_wd;
  logic [1:0][1:0][31:0] o_rdata;
  logic [1:0][1:0]       o_rdv;
  logic [1:0][1:0]       o_wait;
  logic [1:0][3:0]       c_addr;
  logic [1:0][3:0]       c_be;
  logic [1:0]            c_rd;
  logic [1:0]            c_wr;
  logic [1:0][31:0]      c_wd;
  logic [1:0][31:0]      c_rdata;
  logic [31:0]           regs [16];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  cmp_en   = 1'b0;
  bit  rand_en  = 1'b0;
  logic [1:0][1:0] rand_done = '0;

  cd_csr_arb_if a0 (), a1 (), b0 (), b1 ();

  assign a0.address = s_addr[0][0]; assign a0.byteenable = s_be[0][0];
  assign a0.read    = s_rd[0][0];   assign a0.write      = s_wr[0][0];
  assign a0.writedata = s_wd[0][0];
  assign a1.address = s_addr[0][1]; assign a1.byteenable = s_be[0][1];
  assign a1.read    = s_rd[0][1];   assign a1.write      = s_wr[0][1];
  assign a1.writedata = s_wd[0][1];
  assign b0.address = s_addr[1][0]; assign b0.byteenable = s_be[1][0];
  assign b0.read    = s_rd[1][0];   assign b0.write      = s_wr[1][0];
  assign b0.writedata = s_wd[1][0];
  assign b1.address = s_addr[1][1]; assign b1.byteenable = s_be[1][1];
  assign b1.read    = s_rd[1][1];   assign b1.write      = s_wr[1][1];
  assign b1.writedata = s_wd[1][1];

  assign o_rdata[0][0] = a0.readdata; assign o_rdv[0][0] = a0.readdatavalid; assign o_wait[0][0] = a0.waitrequest;
  assign o_rdata[0][1] = a1.readdata; assign o_rdv[0][1] = a1.readdatavalid; assign o_wait[0][1] = a1.waitrequest;
  assign o_rdata[1][0] = b0.readdata; assign o_rdv[1][0] = b0.readdatavalid; assign o_wait[1][0] = b0.waitrequest;
  assign o_rdata[1][1] = b1.readdata; assign o_rdv[1][1] = b1.readdatavalid; assign o_wait[1][1] = b1.waitrequest;

  // Combinational CSR slave: fixed register contents, addressed directly.
  assign c_rdata[0] = regs[c_addr[0]];
  assign c_rdata[1] = regs[c_addr[1]];

  cd_csr_arb #(.FIXED_PRIO(1'b0)) u_rr (
    .clk (clk), .reset_n (reset_n), .m0 (a0), .m1 (a1),
    .csr_address (c_addr[0]), .csr_byteenable (c_be[0]), .csr_read (c_rd[0]),
    .csr_write (c_wr[0]), .csr_writedata (c_wd[0]), .csr_readdata (c_rdata[0])
  );

  cd_csr_arb #(.FIXED_PRIO(1'b1)) u_fp (
    .clk (clk), .reset_n (reset_n), .m0 (b0), .m1 (b1),
    .csr_address (c_addr[1]), .csr_byteenable (c_be[1]), .csr_read (c_rd[1]),
    .csr_write (c_wr[1]), .csr_writedata (c_wd[1]), .csr_readdata (c_rdata[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // A transaction is "age" cycles old: 0 none in flight, 1 strobe cycle,
  // 2 response cycle; it begins when a request is seen with none in flight.
  int          age  [2] = '{0, 0};
  int          gnt  [2] = '{0, 0};
  int          last [2] = '{1, 1};
  bit          mwr  [2];
  logic [3:0]  maddr[2];
  logic [3:0]  mbe  [2];
  logic [31:0] mwd  [2];
  logic [31:0] mrd  [2][2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        age[k] = 0; last[k] = 1;
        mrd[k][0] = '0; mrd[k][1] = '0;
      end else if (age[k] == 0) begin
        bit r0, r1;
        int w;
        r0 = s_rd[k][0] | s_wr[k][0];
        r1 = s_rd[k][1] | s_wr[k][1];
        if (r0 || r1) begin
          if (r0 && r1) w = (k == 1) ? 0 : 1 - last[k];
          else          w = r1 ? 1 : 0;
          gnt[k] = w;
          mwr[k] = s_wr[k][w];
          maddr[k] = s_addr[k][w];
          mbe[k] = s_be[k][w];
          mwd[k] = s_wd[k][w];
          age[k] = 1;
        end
      end else if (age[k] == 1) begin
        if (!mwr[k]) mrd[k][gnt[k]] = regs[maddr[k]];
        age[k] = 2;
      end else begin
        last[k] = gnt[k];
        age[k] = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        bit iss;
        iss = (age[k] == 1);
        check($sformatf("i%0d csr_read", k),  c_rd[k], iss && !mwr[k]);
        check($sformatf("i%0d csr_write", k), c_wr[k], iss && mwr[k]);
        check($sformatf("i%0d csr_address", k),    c_addr[k], iss ? maddr[k] : 4'h0);
        check($sformatf("i%0d csr_byteenable", k), c_be[k],   iss ? mbe[k]   : 4'h0);
        check($sformatf("i%0d csr_writedata", k),  c_wd[k],   iss ? mwd[k]   : 32'h0);
        for (int j = 0; j < 2; j++) begin
          bit rsp;
          rsp = (age[k] == 2) && (gnt[k] == j);
          check($sformatf("i%0d m%0d waitrequest", k, j),   o_wait[k][j], !rsp);
          check($sformatf("i%0d m%0d readdatavalid", k, j), o_rdv[k][j],  rsp && !mwr[k]);
          check($sformatf("i%0d m%0d readdata", k, j),      o_rdata[k][j], mrd[k][j]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  int          ob_nrd, ob_nwr, ob_nrdv, ob_wait_low, ob_strobe_at, ob_rdv_at;
  logic [3:0]  ob_addr, ob_be;
  logic [31:0] ob_wd, ob_rdata;
  int          bq[$];
  int          st[$];

  task automatic present(input int k, input int j, input bit rd, input bit wr,
                         input logic [3:0] addr, input logic [3:0] be, input logic [31:0] wd);
    s_rd[k][j] = rd; s_wr[k][j] = wr; s_addr[k][j] = addr; s_be[k][j] = be; s_wd[k][j] = wd;
  endtask

  // Watch one master for ncyc cycles, dropping its request once accepted.
  // Called just after an edge: iteration 0 is the cycle before the sampling edge.
  task automatic observe(input int k, input int j, input int ncyc);
    bit drop;
    ob_nrd = 0; ob_nwr = 0; ob_nrdv = 0; ob_wait_low = 0;
    ob_strobe_at = -1; ob_rdv_at = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      drop = 1'b0;
      if (c_rd[k] || c_wr[k]) begin
        if (c_rd[k]) ob_nrd++;
        if (c_wr[k]) ob_nwr++;
        if (ob_strobe_at < 0) ob_strobe_at = i;
        ob_addr = c_addr[k]; ob_be = c_be[k]; ob_wd = c_wd[k];
      end
      if (o_rdv[k][j]) begin ob_nrdv++; ob_rdv_at = i; ob_rdata = o_rdata[k][j]; end
      if (!o_wait[k][j]) begin ob_wait_low++; drop = 1'b1; end
      @(posedge clk); #1;
      if (drop) begin s_rd[k][j] = 1'b0; s_wr[k][j] = 1'b0; end
    end
  endtask

  // Both masters start together and re-present reads immediately after each
  // acceptance until n0 / n1 reads are done; records grant order and strobe times.
  task automatic burst(input int k, input int n0, input int n1);
    int left[2];
    bit acc[2];
    left[0] = n0; left[1] = n1;
    bq.delete(); st.delete();
    for (int j = 0; j < 2; j++)
      if (left[j] > 0) present(k, j, 1'b1, 1'b0, 4'($urandom), 4'hF, 32'h0);
    for (int c = 0; c < 80 && (left[0] > 0 || left[1] > 0); c++) begin
      @(negedge clk);
      if (c_rd[k] || c_wr[k]) st.push_back(cyc);
      for (int j = 0; j < 2; j++) begin
        acc[j] = !o_wait[k][j];
        if (o_rdv[k][j]) bq.push_back(j);
      end
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        if (acc[j] && left[j] > 0) begin
          left[j]--;
          if (left[j] == 0) s_rd[k][j] = 1'b0;
          else s_addr[k][j] = 4'($urandom);
        end
      end
    end
    check("burst completed", left[0] + left[1], 0);
  endtask

  // ---------------- randomized masters ----------------
  for (genvar gk = 0; gk < 2; gk++) begin : g_k
    for (genvar gj = 0; gj < 2; gj++) begin : g_j
      initial begin
        int  t;
        bit  accepted;
        wait (rand_en);
        @(posedge clk); #1;
        while (rand_en) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          t = $urandom_range(0, 7);
          s_rd[gk][gj]   = (t < 4) || (t >= 6);
          s_wr[gk][gj]   = (t >= 4) && (t <= 6);
          s_addr[gk][gj] = 4'($urandom);
          s_be[gk][gj]   = 4'($urandom);
          s_wd[gk][gj]   = $urandom;
          if (t == 7) begin
            // Drop after one cycle whether or not it was latched.
            @(posedge clk); #1;
          end else begin
            accepted = 1'b0;
            for (int c = 0; c < 40; c++) begin
              @(negedge clk);
              if (!o_wait[gk][gj]) begin accepted = 1'b1; break; end
            end
            @(posedge clk); #1;
            check($sformatf("i%0d m%0d accepted", gk, gj), accepted, 1'b1);
          end
          s_rd[gk][gj] = 1'b0;
          s_wr[gk][gj] = 1'b0;
        end
        rand_done[gk][gj] = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] m0_prev;
    bit ok;
    reset_n = 1'b0;
    s_addr = '0; s_be = '0; s_rd = '0; s_wr = '0; s_wd = '0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    regs[0] = 32'h0000_000C;
    regs[9] = 32'hDEAD_0009;

    @(posedge clk); #1; cmp_en = 1'b1;
    @(posedge clk); #1; reset_n = 1'b1;

    // Reset values.
    @(negedge clk);
    check("reset csr_read",  c_rd[0], 1'b0);
    check("reset csr_write", c_wr[0], 1'b0);
    check("reset m0 waitrequest", o_wait[0][0], 1'b1);
    check("reset m1 waitrequest", o_wait[0][1], 1'b1);
    check("reset m0 readdata",    o_rdata[0][0], 32'h0);
    @(posedge clk); #1;

    // Single read, m0, address 0.
    present(0, 0, 1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
    observe(0, 0, 6);
    check("read strobe count", ob_nrd, 1);
    check("read strobe at E+1", ob_strobe_at, 1);
    check("read rdv at E+2", ob_rdv_at, 2);
    check("read data", ob_rdata, 32'h0000_000C);
    check("read waitrequest low cycles", ob_wait_low, 1);

    // Single write, m1, address 0xC.
    present(0, 1, 1'b0, 1'b1, 4'hC, 4'h1, 32'h0000_0002);
    observe(0, 1, 6);
    check("write strobe count", ob_nwr, 1);
    check("write no read strobe", ob_nrd, 0);
    check("write address", ob_addr, 4'hC);
    check("write data", ob_wd, 32'h2);
    check("write byteenable", ob_be, 4'h1);
    check("write no rdv", ob_nrdv, 0);
    check("write m1 readdata unchanged", o_rdata[0][1], 32'h0);

    // Round-robin: 4 reads each, m0 first because m1 was granted last.
    burst(0, 4, 4);
    check("rr response count", bq.size(), 8);
    check("rr strobe count", st.size(), 8);
    for (int i = 0; i < bq.size(); i++) check("rr grant order", bq[i], i % 2);
    for (int i = 1; i < st.size(); i++) check("rr strobe spacing", st[i] - st[i-1], 3);

    // Fixed priority: m0 holds for 5 reads, m1 waits then follows at once.
    burst(1, 5, 1);
    check("fp response count", bq.size(), 6);
    for (int i = 0; i < bq.size(); i++) check("fp grant order", bq[i], (i == 5) ? 1 : 0);
    for (int i = 1; i < st.size(); i++) check("fp strobe spacing", st[i] - st[i-1], 3);

    // Read and write both high: treated as a write.
    m0_prev = o_rdata[0][0];
    present(0, 0, 1'b1, 1'b1, 4'h9, 4'hF, 32'h1234_5678);
    observe(0, 0, 6);
    check("rw write strobes", ob_nwr, 1);
    check("rw read strobes", ob_nrd, 0);
    check("rw no rdv", ob_nrdv, 0);
    check("rw readdata unchanged", o_rdata[0][0], m0_prev);

    // Reset asserted during ISSUE; request held and re-granted afterwards.
    present(0, 0, 1'b1, 1'b0, 4'h0, 4'hF, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("issue strobe before reset", c_rd[0], 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset csr_read",    c_rd[0], 1'b0);
    check("post-reset csr_write",   c_wr[0], 1'b0);
    check("post-reset csr_address", c_addr[0], 4'h0);
    check("post-reset m0 waitrequest", o_wait[0][0], 1'b1);
    check("post-reset m1 waitrequest", o_wait[0][1], 1'b1);
    reset_n = 1'b1;
    observe(0, 0, 8);
    check("regrant read strobes", ob_nrd, 1);
    check("regrant rdv", ob_nrdv, 1);
    check("regrant data", ob_rdata, 32'h0000_000C);
    check("regrant accepted", ob_wait_low, 1);

    // Randomized traffic on both instances with occasional resets.
    rand_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(200, 500)) @(posedge clk);
      #1; reset_n = 1'b0;
      @(posedge clk); #1; reset_n = 1'b1;
    end
    rand_en = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (&rand_done) begin ok = 1'b1; break; end
    end
    check("random masters finished", ok, 1'b1);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cd_csr_arb.md
# cd_csr_arb

Two-master arbiter that shares the single CDBUS controller CSR slave port between two independent bus masters, for example an on-chip CPU and a SPI-to-CSR bridge. It serialises accesses so that every accepted write produces exactly one `csr_write` strobe. Without this guarantee, single-shot command bits such as RX/TX control could double-fire. It captures the slave's combinational read data into a registered response for the granted master. It sits directly in front of the CSR block, and its `csr_*` outputs drive that block's inputs one-to-one.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between masters; 1 = m0 always wins a simultaneous request.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `m0_address` / `m1_address`  in  4  register word address.
- `m0_byteenable` / `m1_byteenable`  in  4  byte lanes.
- `m0_read` / `m1_read`  in  1  read request, held until accepted.
- `m0_write` / `m1_write`  in  1  write request, held until accepted.
- `m0_writedata` / `m1_writedata`  in  32  write data.
- `m0_readdata` / `m1_readdata`  out  32  registered response data.
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  one-cycle read response strobe.
- `m0_waitrequest` / `m1_waitrequest`  out  1  high = request not yet accepted.
- `csr_address`  out  4  to slave.
- `csr_byteenable`  out  4  to slave.
- `csr_read`  out  1  to slave.
- `csr_write`  out  1  to slave.
- `csr_writedata`  out  32  to slave.
- `csr_readdata`  in  32  combinational read data from slave.

## Operation
- FSM has three states: IDLE, ISSUE, RESP. Each transaction takes 3 cycles, so one transaction completes per 3 cycles at best.
- **IDLE**
  - A master requests when its `mN_read | mN_write` is high.
  - With no request, stay in IDLE.
  - With a request, pick the grant: a single requester wins; on a tie, the winner follows `FIXED_PRIO`, otherwise the master not granted last.
  - Register the winner's address, byteenable, writedata and type, then go to ISSUE.
- **Type rule:** if `mN_read` and `mN_write` are both high, the access is a write and no read response is given.
- **ISSUE**
  - Drive `csr_read` or `csr_write` high for exactly this one cycle, together with the registered command fields.
  - For a read, capture `csr_readdata` into the granted master's readdata register.
  - Go to RESP.
- **RESP**
  - Granted master: `mN_waitrequest` = 0 for this one cycle.
  - For a read only: `mN_readdatavalid` = 1 in the same cycle.
  - Update the last-grant record, then go to IDLE.
- **Request dropped early:** if the master drops its request after it has been latched in IDLE, the transaction still completes and the RESP pulses are still issued.
- **Ungranted master:** its `waitrequest` stays 1 and its `readdatavalid` stays 0. Its `readdata` holds its previous value.
- **Readdata persistence:** each master's `readdata` holds its value until that master's next read completes. A write leaves it unchanged.

## Timing
- Request sampled at edge E (IDLE) → `csr_*` strobe in cycle E+1 → acceptance/response in cycle E+2 → back in IDLE at E+3.
- **Reset values:** state IDLE; all `csr_*` outputs 0; `mN_waitrequest` = 1; `mN_readdatavalid` = 0; `mN_readdata` = 0; last grant = m1, so m0 wins the first tie.
- **Reset mid-transaction:**
  - The transaction is dropped.
  - A `csr_write` cut off by reset is never issued.
  - The master sees no acceptance and must re-present the request.
- **Strobe discipline:**
  - `csr_read` and `csr_write` are never both high.
  - Neither is ever high for two consecutive cycles.
  - They are high only in ISSUE.
- **Back-to-back:** a request held continuously by the other master is granted in the IDLE cycle immediately after RESP.
- **Starvation:** none under round-robin, since the masters alternate whenever both request continuously.

## Structure
- Shared package `cd_csr_arb_pkg` holds:
  - the state encoding (IDLE=0, ISSUE=1, RESP=2);
  - the widths `CSR_AW=4` and `CSR_DW=32`;
  - the master index type.
- Sub-module `cd_rr_pick`: a combinational 2-way picker. Inputs are the request vector, the last-grant bit and `FIXED_PRIO`; output is the grant index.
- FSM, command register and response registers live in the top.

## Test plan
- **Single read:** m0 reads address 0x0, slave returns 0x0000000C.
  - `csr_read` high exactly 1 cycle at E+1.
  - `m0_readdatavalid` = 1 with `m0_readdata` = 0x0000000C at E+2.
  - `m0_waitrequest` = 0 only in that cycle.
- **Write strobe count:** m1 writes 0x02 to address 0xC with byteenable 0x1.
  - Exactly one `csr_write` cycle carries address 0xC and data 0x02.
  - `m1_readdatavalid` stays 0 and `m1_readdata` is unchanged.
- **Simultaneous continuous requests, `FIXED_PRIO`=0:** both masters issue 4 reads each.
  - Grants alternate m0, m1, m0, m1, …
  - 8 strobes total, 3 cycles apart.
- **Simultaneous requests, `FIXED_PRIO`=1:** m0 holds requests continuously.
  - m1 receives no grant until m0 drops its request.
  - m1 is granted in the next IDLE cycle.
- **Read and write both high:** m0 asserts read=1, write=1, address 0x9.
  - One `csr_write`, no `csr_read`.
  - No `readdatavalid`.
- **Reset in ISSUE:** `reset_n` = 0 asserted during ISSUE.
  - Next cycle: all `csr_*` = 0, both `waitrequest` = 1, state IDLE.
  - After reset is released, the held request is re-granted and completes normally.
